spi_slave: RTL

- SPI responder (mode 0: CPOL=0, CPHA=0). It is the far-end counterpart of spi_master and is used as a bench/loopback target and for FPGA-side register access.
- Each frame has two phases. First it receives a RX_WIDTH-bit command/data word, MSB first. It then returns a TX_WIDTH-bit response word, MSB first.
- All pin inputs are oversampled in the sys_clk domain. There is no logic clocked by SCLK.

---
 rtl/spi_slave.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI mode-0 (CPOL=0, CPHA=0) responder. Each frame receives an
//            RX_WIDTH-bit word on MOSI (MSB first), then returns a
//            TX_WIDTH-bit response on MISO (MSB first). All pin inputs are
//            oversampled in the sys_clk domain; nothing is clocked by SCLK.
// Options  : `define SPI_SLAVE_ECHO_EN to return rx_data[TX_WIDTH-1:0] as the
//            response instead of tx_data (tx_data port is then ignored).
// Ports    : sys_clk   - system clock
//            sys_rst   - asynchronous active-high reset
//            sclk_pin  - SPI clock from master
//            ncs_pin   - chip select, active low
//            mosi_pin  - master-out data
//            miso_pin  - slave-out data
//            miso_oe   - MISO pad output enable
//            rx_data   - last received word
//            rx_valid  - one-cycle pulse when rx_data updates
//            tx_data   - response word, sampled while rx_valid is high
//            frame_err - one-cycle pulse when a frame is aborted in RX
//            busy      - high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave #(
   parameter int RX_WIDTH    = 32,
   parameter int TX_WIDTH    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                sclk_pin,
   input  logic                ncs_pin,
   input  logic                mosi_pin,
   output logic                miso_pin,
   output logic                miso_oe,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
   input  logic [TX_WIDTH-1:0] tx_data,
   output logic                frame_err,
   output logic                busy
);

   // bit_cnt spans the whole frame (RX bits then TX bits) and saturates.
   localparam int c_CNT_W = $clog2(RX_WIDTH + TX_WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_RX_LAST = c_CNT_W'(RX_WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RX_WIDTH + TX_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RX   = 3'd1,
      ST_LOAD = 3'd2,
      ST_TX   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ncs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   ncs_prev_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sclk_sync_q <= '0;
         ncs_sync_q  <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0],  ncs_pin};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
      end
   end

   logic w_sclk_s;
   logic w_ncs_s;
   logic w_mosi_s;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_fall;

   assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign w_ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   // mosi and sclk share the same depth, so mosi is aligned with sclk_rise.
   assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk_s & ~sclk_prev_q;
   assign w_sclk_fall = ~w_sclk_s &  sclk_prev_q;
   assign w_cs_fall   = ~w_ncs_s  &  ncs_prev_q;

   // ------------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------------
   state_t                state_q;
   logic [c_CNT_W-1:0]    bit_cnt_q;
   logic [RX_WIDTH-1:0]   rx_shift_q;
   logic [TX_WIDTH-1:0]   tx_shift_q;
   logic                  tx_started_q;
   logic [RX_WIDTH-1:0]   rx_data_q;
   logic                  rx_valid_q;
   logic                  frame_err_q;
   logic                  miso_q;
   logic                  miso_oe_q;

   logic [RX_WIDTH-1:0]   w_rx_next;
   logic [TX_WIDTH-1:0]   w_tx_src;
   logic [TX_WIDTH-1:0]   w_tx_shifted;

   assign w_rx_next    = {rx_shift_q[RX_WIDTH-2:0], w_mosi_s};
   assign w_tx_shifted = tx_shift_q << 1;

`ifdef SPI_SLAVE_ECHO_EN
   // rx_data_q already holds the completed word while in LOAD.
   assign w_tx_src = rx_data_q[TX_WIDTH-1:0];
`else
   assign w_tx_src = tx_data;
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         rx_shift_q   <= '0;
         tx_shift_q   <= '0;
         tx_started_q <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         miso_q       <= 1'b0;
         miso_oe_q    <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;

         // Chip-select release overrides everything, including a coincident
         // sclk_rise (that bit is discarded).
         if ((state_q != ST_IDLE) && w_ncs_s) begin
            state_q   <= ST_IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            if (state_q == ST_RX) begin
               frame_err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
                  if (w_cs_fall) begin
                     bit_cnt_q    <= '0;
                     rx_shift_q   <= '0;
                     tx_shift_q   <= '0;
                     tx_started_q <= 1'b0;
                     state_q      <= ST_RX;
                  end
               end

               ST_RX: begin
                  if (w_sclk_rise) begin
                     rx_shift_q <= w_rx_next;
                     bit_cnt_q  <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == c_RX_LAST) begin
                        rx_data_q  <= w_rx_next;
                        rx_valid_q <= 1'b1;
                        state_q    <= ST_LOAD;
                     end
                  end
               end

               ST_LOAD: begin
                  tx_shift_q <= w_tx_src;
                  miso_oe_q  <= 1'b1;
                  // A fall landing in this very cycle would otherwise be
                  // lost, so present the MSB straight from the source.
                  if (w_sclk_fall) begin
                     miso_q       <= w_tx_src[TX_WIDTH-1];
                     tx_started_q <= 1'b1;
                     bit_cnt_q    <= bit_cnt_q + 1'b1;
                  end else begin
                     tx_started_q <= 1'b0;
                  end
                  state_q <= ST_TX;
               end

               ST_TX: begin
                  if (w_sclk_fall) begin
                     if (!tx_started_q) begin
                        // First fall: present MSB without shifting.
                        miso_q       <= tx_shift_q[TX_WIDTH-1];
                        tx_started_q <= 1'b1;
                        bit_cnt_q    <= bit_cnt_q + 1'b1;
                     end else if (bit_cnt_q != c_CNT_MAX) begin
                        tx_shift_q <= w_tx_shifted;
                        miso_q     <= w_tx_shifted[TX_WIDTH-1];
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                     end
                  end else if (w_sclk_rise && (bit_cnt_q == c_CNT_MAX)) begin
                     // Master has sampled the last bit.
                     state_q <= ST_DONE;
                  end
               end

               ST_DONE: begin
                  // Hold last bit; further SCLK activity is ignored.
                  miso_oe_q <= 1'b1;
               end

               default: begin
                  state_q   <= ST_IDLE;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign miso_pin  = miso_q;
   assign miso_oe   = miso_oe_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire
